// File: rtl/buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : buf_ctrl_pkg
// Description : Shared types and constants for the multi-bank input-buffer
//               controller: FSM state encoding, legal bank-count range and
//               the bank-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package buf_ctrl_pkg;

  // Legal range for the number of banks in the ring
  localparam int NUM_BANKS_MIN = 2;
  localparam int NUM_BANKS_MAX = 8;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_e;

  // Bank index width: at least one bit even for a two-bank ring
  function automatic int calc_bank_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_bank_buf_ctrl_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ring_ptr
// Description : Modulo-NUM_BANKS increment of a bank pointer. Purely
//               combinational; the caller decides when to take the new value.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_ptr
  import buf_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = calc_bank_w(NUM_BANKS)
) (
  input  logic [BANK_W-1:0] ptr_i,
  output logic [BANK_W-1:0] ptr_inc_o
);

  localparam logic [BANK_W-1:0] c_LAST_BANK = BANK_W'(NUM_BANKS - 1);

  // Wrap from the last bank back to bank 0 (ring need not be a power of two)
  assign ptr_inc_o = (ptr_i == c_LAST_BANK) ? '0 : (ptr_i + BANK_W'(1));

endmodule
`default_nettype wire

// File: rtl/multi_bank_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_bank_buf_ctrl
// Description : Ring-buffer controller for NUM_BANKS input-buffer banks.
//               Tracks writer/reader bank pointers, occupancy and per-layer
//               tile counts; flags protocol violations in a sticky err bit.
//               Optional stall counters are built when the macro
//               MULTI_BANK_BUF_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bank_buf_ctrl
  import buf_ctrl_pkg::*;
#(
  parameter  int NUM_BANKS  = 2,
  parameter  int TILE_CNT_W = 16,
  localparam int BANK_W     = calc_bank_w(NUM_BANKS)
) (
  input  logic                  clki,
  input  logic                  rst,
  input  logic                  ctrl_start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  input  logic                  write_finish,
  input  logic                  done_tile,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank,
  output logic                  wr_ready,
  output logic                  inbuffer_enout,
  output logic [BANK_W:0]       occupancy,
  output logic                  busy,
  output logic                  layer_done,
`ifdef MULTI_BANK_BUF_PERF_EN
  output logic [31:0]           wr_stall_cnt,
  output logic [31:0]           rd_stall_cnt,
`endif
  output logic                  err
);

  localparam logic [BANK_W:0]       c_OCC_FULL  = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [TILE_CNT_W-1:0] c_TILE_ZERO = '0;

  // Reject illegal bank counts at elaboration
  if ((NUM_BANKS < NUM_BANKS_MIN) || (NUM_BANKS > NUM_BANKS_MAX)) begin : g_bad_num_banks
    $error("multi_bank_buf_ctrl: NUM_BANKS out of legal range");
  end

  buf_state_e            state_q;
  logic [TILE_CNT_W-1:0] num_q, wr_cnt_q, rd_cnt_q;
  logic [TILE_CNT_W-1:0] wr_cnt_d, rd_cnt_d;
  logic [BANK_W-1:0]     wr_bank_q, rd_bank_q, wr_bank_d, rd_bank_d;
  logic [BANK_W-1:0]     w_wr_bank_inc, w_rd_bank_inc;
  logic [BANK_W:0]       occ_q, occ_d;
  logic                  wr_ready_q, enout_q, busy_q, layer_done_q, err_q;
  logic                  w_start_any, w_start_run;
  logic                  w_wr_acc, w_rd_acc, w_viol, w_wr_last, w_rd_last;

  ring_ptr #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_wr_ptr (
    .ptr_i     (wr_bank_q),
    .ptr_inc_o (w_wr_bank_inc)
  );

  ring_ptr #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_rd_ptr (
    .ptr_i     (rd_bank_q),
    .ptr_inc_o (w_rd_bank_inc)
  );

  // Handshake acceptance and next values of counters, occupancy and pointers
  always_comb begin
    w_start_any = (state_q == ST_IDLE) && ctrl_start;
    w_start_run = w_start_any && (num_tiles != c_TILE_ZERO);
    // wr_ready/enout are only ever high outside IDLE, so accepts imply RUN/DRAIN
    w_wr_acc    = write_finish && wr_ready_q;
    w_rd_acc    = done_tile && enout_q;
    w_viol      = (write_finish && !wr_ready_q) || (done_tile && !enout_q);
    wr_cnt_d    = wr_cnt_q + TILE_CNT_W'(w_wr_acc);
    rd_cnt_d    = rd_cnt_q + TILE_CNT_W'(w_rd_acc);
    occ_d       = occ_q + (BANK_W + 1)'(w_wr_acc) - (BANK_W + 1)'(w_rd_acc);
    wr_bank_d   = w_wr_acc ? w_wr_bank_inc : wr_bank_q;
    rd_bank_d   = w_rd_acc ? w_rd_bank_inc : rd_bank_q;
    w_wr_last   = w_wr_acc && (wr_cnt_d == num_q);
    w_rd_last   = w_rd_acc && (rd_cnt_d == num_q);
  end

  // Tile counters, occupancy and bank pointers; a running start clears them
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      num_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      occ_q     <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
    end else if (w_start_run) begin
      num_q     <= num_tiles;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      occ_q     <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      occ_q     <= occ_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Layer FSM with registered ready/enable/busy/done/err outputs
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ready_q   <= 1'b0;
      enout_q      <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      // Dropped pulses are sticky; only a start that opens a layer clears err
      err_q        <= (w_start_run ? 1'b0 : err_q) | w_viol;
      case (state_q)
        ST_IDLE: begin
          if (w_start_run) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b1;
            enout_q    <= 1'b0;
          end else if (w_start_any) begin
            // Empty layer: nothing to move, report completion immediately
            layer_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          enout_q <= (occ_d != '0);
          if (w_wr_last) begin
            state_q    <= ST_DRAIN;
            wr_ready_q <= 1'b0;
          end else begin
            wr_ready_q <= (occ_d < c_OCC_FULL);
          end
        end
        ST_DRAIN: begin
          if (w_rd_last) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            enout_q      <= 1'b0;
            layer_done_q <= 1'b1;
          end else begin
            enout_q <= (occ_d != '0);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b0;
          enout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign wr_bank        = wr_bank_q;
  assign rd_bank        = rd_bank_q;
  assign occupancy      = occ_q;
  assign wr_ready       = wr_ready_q;
  assign inbuffer_enout = enout_q;
  assign busy           = busy_q;
  assign layer_done     = layer_done_q;
  assign err            = err_q;

`ifdef MULTI_BANK_BUF_PERF_EN
  logic [31:0] wr_stall_q, rd_stall_q;

  // Saturating stall counters, cleared by any start taken in IDLE
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else if (w_start_any) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      if ((state_q == ST_RUN) && !wr_ready_q && (wr_stall_q != '1)) begin
        wr_stall_q <= wr_stall_q + 32'd1;
      end
      if ((state_q != ST_IDLE) && !enout_q && (rd_stall_q != '1)) begin
        rd_stall_q <= rd_stall_q + 32'd1;
      end
    end
  end

  assign wr_stall_cnt = wr_stall_q;
  assign rd_stall_cnt = rd_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/multi_bank_buf_ctrl.md
MULTI_BANK_BUF_CTRL -- requirements
Module: multi_bank_buf_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of input-buffer banks in the ring (legal range 2..8; need not be a power of two).
REQ-002 SHALL have parameter TILE_CNT_W, default 16, width of the tile counters and of num_tiles.
REQ-003 SHALL have derived localparam BANK_W = max(1, clog2(NUM_BANKS)), the bank index width.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clki  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- ctrl_start  input  1  layer start pulse.
- num_tiles  input  TILE_CNT_W  tiles in the layer; sampled only on an accepted ctrl_start.
- write_finish  input  1  pulse: writer has completed bank wr_bank.
- done_tile  input  1  pulse: reader has consumed bank rd_bank.
- wr_bank  output  BANK_W  bank the writer fills.
- rd_bank  output  BANK_W  bank the reader consumes.
- wr_ready  output  1  writer may fill wr_bank.
- inbuffer_enout  output  1  rd_bank holds valid data; reader enable.
- occupancy  output  BANK_W+1  count of filled, unconsumed banks.
- busy  output  1  layer in progress.
- layer_done  output  1  one-cycle pulse when the last tile has been consumed.
- err  output  1  sticky protocol-violation flag.

Function
REQ-005 SHALL implement states IDLE, RUN and DRAIN.
REQ-006 IDLE -> RUN SHALL occur on ctrl_start with num_tiles != 0; the start SHALL also latch num_tiles, clear wr_cnt, rd_cnt, occupancy and both bank pointers, and clear err.
REQ-007 ctrl_start with num_tiles == 0 SHALL keep the block in IDLE and pulse layer_done on the next cycle.
REQ-008 ctrl_start outside IDLE SHALL be ignored.
REQ-009 An accepted write SHALL require write_finish && wr_ready; it increments wr_cnt and occupancy and advances wr_bank modulo NUM_BANKS (NUM_BANKS-1 -> 0).
REQ-010 An accepted read SHALL require done_tile && inbuffer_enout; it increments rd_cnt, decrements occupancy and advances rd_bank modulo NUM_BANKS.
REQ-011 When a write and a read are accepted in the same cycle, both pointers SHALL advance and occupancy SHALL be unchanged.
REQ-012 wr_ready SHALL be 1 only in RUN with occupancy < NUM_BANKS.
REQ-013 inbuffer_enout SHALL equal (occupancy != 0) in RUN or DRAIN, and 0 in IDLE.
REQ-014 RUN -> DRAIN SHALL occur on the accepted write that makes wr_cnt == num_tiles.
REQ-015 DRAIN -> IDLE SHALL occur on the accepted read that makes rd_cnt == num_tiles, with layer_done pulsed in the same transition.
REQ-016 All outputs SHALL be registered; pointer, occupancy and ready/enable updates SHALL be visible exactly one cycle after the accepting edge.
REQ-017 A write_finish pulse when wr_ready == 0, or a done_tile pulse when inbuffer_enout == 0, SHALL be dropped and SHALL set err.
REQ-018 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-019 While rst is high, the block SHALL be in IDLE with every output, counter and pointer at 0, independent of clki.
REQ-020 Reset asserted mid-layer SHALL abort the layer with no layer_done pulse.

Configuration
REQ-021 With macro MULTI_BANK_BUF_PERF_EN defined, the block SHALL add 32-bit outputs:
- wr_stall_cnt: counts RUN cycles with wr_ready == 0.
- rd_stall_cnt: counts RUN/DRAIN cycles with inbuffer_enout == 0.
- Both counters saturate at all-ones and clear on an accepted ctrl_start and on reset.
REQ-022 Without MULTI_BANK_BUF_PERF_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 The state encoding type and the NUM_BANKS legal-range constants SHALL reside in the shared package buf_ctrl_pkg.
REQ-024 Modulo-NUM_BANKS pointer increment SHALL be one sub-module, ring_ptr, instantiated once for the write pointer and once for the read pointer.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- NUM_BANKS=2, num_tiles=4, alternating write/read -> wr_bank sequence 0,1,0,1; layer_done pulses once after the 4th done_tile; busy then drops.
- NUM_BANKS=3, 3 writes with no reads -> occupancy=3, wr_ready=0; a 4th write_finish sets err and leaves occupancy at 3.
- NUM_BANKS=3, occupancy=1, write_finish and done_tile in the same cycle -> occupancy stays 1, both pointers advance, wr_bank wraps 2 -> 0.
- num_tiles=0 on ctrl_start -> layer_done on the next cycle; busy stays 0.
- rst asserted in DRAIN with occupancy=2 -> all outputs 0 immediately; no layer_done.
- PERF_EN defined, reader idle for 10 RUN cycles -> rd_stall_cnt=10.
